// File: rtl/spi_ip_shift_engine.sv
// SPI master shift engine: sequences slave select, enables the tick generator,
// shifts one word out on MOSI while sampling MISO, and reports the received word.
module spi_ip_shift_engine #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  se_clk_i,
    input  logic                  se_rst_n_i,
    input  logic                  se_start_i,
    input  logic                  se_abort_i,
    input  logic [DATA_WIDTH-1:0] se_tx_data_i,
    input  logic                  se_lsb_first_i,
    input  logic                  se_sck_pha_i,
    input  logic                  se_tick_i,
    input  logic                  se_tick_launch_i,
    input  logic                  se_tick_capture_i,
    input  logic                  se_miso_i,
    output logic                  se_enable_tick_o,
    output logic                  se_enable_sck_o,
    output logic                  se_enable_launch_capture_o,
    output logic                  se_ss_n_o,
    output logic                  se_mosi_o,
    output logic                  se_busy_o,
    output logic                  se_done_o,
    output logic [DATA_WIDTH-1:0] se_rx_data_o
);
    localparam int unsigned CntW = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastEdge = CntW'(2 * DATA_WIDTH - 1);
    localparam logic [CntW-1:0] AllEdges = CntW'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  lsb_q, lsb_d;
    logic                  pha_q, pha_d;
    logic                  ss_n_q, ss_n_d;
    logic                  en_tick_q, en_tick_d;
    logic                  en_sck_q, en_sck_d;
    logic                  en_lc_q, en_lc_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  launch_holds;

    // First CPHA=1 launch only presents the preloaded bit; last CPHA=0 launch is the trailing edge.
    assign launch_holds = (pha_q && (cnt_q == '0)) || (!pha_q && (cnt_q == LastEdge));

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        lsb_d     = lsb_q;
        pha_d     = pha_q;
        ss_n_d    = ss_n_q;
        en_tick_d = en_tick_q;
        en_sck_d  = en_sck_q;
        en_lc_d   = en_lc_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        if (se_abort_i && (state_q != StIdle)) begin
            // Abort overrides every strobe; rx_data is deliberately preserved.
            state_d   = StIdle;
            ss_n_d    = 1'b1;
            en_tick_d = 1'b0;
            en_sck_d  = 1'b0;
            en_lc_d   = 1'b0;
            mosi_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (se_start_i && !se_abort_i) begin
                        tx_d      = se_tx_data_i;
                        rx_d      = '0;
                        lsb_d     = se_lsb_first_i;
                        pha_d     = se_sck_pha_i;
                        mosi_d    = se_lsb_first_i ? se_tx_data_i[0]
                                                   : se_tx_data_i[DATA_WIDTH-1];
                        ss_n_d    = 1'b0;
                        en_tick_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = StLead;
                    end
                end
                StLead: begin
                    if (se_tick_i) begin
                        en_sck_d = 1'b1;
                        en_lc_d  = 1'b1;
                        state_d  = StXfer;
                    end
                end
                StXfer: begin
                    if (cnt_q == AllEdges) begin
                        en_sck_d = 1'b0;
                        en_lc_d  = 1'b0;
                        state_d  = StTrail;
                    end else if (se_tick_capture_i) begin
                        // Also covers a simultaneous launch: one edge, capture only.
                        cnt_d = cnt_q + 1'b1;
                        rx_d  = lsb_q ? {se_miso_i, rx_q[DATA_WIDTH-1:1]}
                                      : {rx_q[DATA_WIDTH-2:0], se_miso_i};
                    end else if (se_tick_launch_i) begin
                        cnt_d = cnt_q + 1'b1;
                        if (!launch_holds) begin
                            if (lsb_q) begin
                                tx_d   = tx_q >> 1;
                                mosi_d = tx_q[1];
                            end else begin
                                tx_d   = tx_q << 1;
                                mosi_d = tx_q[DATA_WIDTH-2];
                            end
                        end
                    end
                end
                StTrail: begin
                    if (se_tick_i) begin
                        ss_n_d    = 1'b1;
                        en_tick_d = 1'b0;
                        mosi_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_q;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge se_clk_i or negedge se_rst_n_i) begin
        if (!se_rst_n_i) begin
            state_q   <= StIdle;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
            lsb_q     <= 1'b0;
            pha_q     <= 1'b0;
            ss_n_q    <= 1'b1;
            en_tick_q <= 1'b0;
            en_sck_q  <= 1'b0;
            en_lc_q   <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
            lsb_q     <= lsb_d;
            pha_q     <= pha_d;
            ss_n_q    <= ss_n_d;
            en_tick_q <= en_tick_d;
            en_sck_q  <= en_sck_d;
            en_lc_q   <= en_lc_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign se_enable_tick_o           = en_tick_q;
    assign se_enable_sck_o            = en_sck_q;
    assign se_enable_launch_capture_o = en_lc_q;
    assign se_ss_n_o                  = ss_n_q;
    assign se_mosi_o                  = mosi_q;
    assign se_busy_o                  = busy_q;
    assign se_done_o                  = done_q;
    assign se_rx_data_o               = rx_data_q;
endmodule

// File: tb/tb_spi_ip_shift_engine.sv
// Bench for spi_ip_shift_engine: a behavioural tick generator and SPI slave drive the
// strobes and MISO; transfers are judged against the words and bit orders requested.
module tb_spi_ip_shift_engine;
    localparam int DW = 8;

    logic          clk, rst_n, start, abort, lsb, pha;
    logic [DW-1:0] tx_data;
    logic          tick, launch, capture, miso;
    logic          en_tick, en_sck, en_lc, ss_n, mosi, busy, done;
    logic [DW-1:0] rx_data;

    // Environment state
    int            div, div_cnt, edge_idx;
    logic          loopback;
    logic [DW-1:0] miso_word;
    // Observations
    int            n_edges, cap_n, done_n, ssn_bad;
    logic [DW-1:0] mosi_seen;
    int            n_checks, n_err;

    spi_ip_shift_engine #(.DATA_WIDTH(DW)) dut (
        .se_clk_i                   (clk),
        .se_rst_n_i                 (rst_n),
        .se_start_i                 (start),
        .se_abort_i                 (abort),
        .se_tx_data_i               (tx_data),
        .se_lsb_first_i             (lsb),
        .se_sck_pha_i               (pha),
        .se_tick_i                  (tick),
        .se_tick_launch_i           (launch),
        .se_tick_capture_i          (capture),
        .se_miso_i                  (miso),
        .se_enable_tick_o           (en_tick),
        .se_enable_sck_o            (en_sck),
        .se_enable_launch_capture_o (en_lc),
        .se_ss_n_o                  (ss_n),
        .se_mosi_o                  (mosi),
        .se_busy_o                  (busy),
        .se_done_o                  (done),
        .se_rx_data_o               (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick generator and SPI slave model, updated between active edges.
    always @(negedge clk) begin
        tick    = 1'b0;
        launch  = 1'b0;
        capture = 1'b0;
        if (en_tick) begin
            if (div_cnt >= div - 1) begin
                div_cnt = 0;
                tick    = 1'b1;
            end else begin
                div_cnt++;
            end
        end else begin
            div_cnt = 0;
        end
        if (!en_lc) begin
            edge_idx = 0;
        end else if (tick) begin
            // CPHA=1 launches on even edges; CPHA=0 captures on even edges.
            if (((edge_idx % 2) == 0) == pha) begin
                launch = 1'b1;
            end else begin
                capture = 1'b1;
                if (cap_n < DW) begin
                    mosi_seen[cap_n] = mosi;
                    miso = loopback ? mosi : miso_word[lsb ? cap_n : DW - 1 - cap_n];
                end
                cap_n++;
            end
            edge_idx++;
            n_edges++;
        end
        if (done) done_n++;
        if (busy && ss_n) ssn_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected MOSI order: bit i of the result is the i-th bit put on the wire.
    function automatic logic [DW-1:0] wire_order(input logic [DW-1:0] w, input logic l);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = l ? w[i] : w[DW-1-i];
        return r;
    endfunction

    task automatic clear_obs();
        n_edges   = 0;
        cap_n     = 0;
        done_n    = 0;
        ssn_bad   = 0;
        mosi_seen = '0;
    endtask

    task automatic start_xfer(input logic [DW-1:0] t, input logic [DW-1:0] mw, input logic l,
                              input logic p, input logic lp, input int d);
        tx_data   = t;
        miso_word = mw;
        lsb       = l;
        pha       = p;
        loopback  = lp;
        div       = d;
        clear_obs();
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_edges(input string tag, input int n);
        for (int k = 0; k < 2000 && n_edges < n; k++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_edges_reached"}, (n_edges >= n), 1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic check_xfer(input string tag, input logic [DW-1:0] t, input logic l,
                              input logic [DW-1:0] exp_rx);
        check({tag, "_mosi_seq"}, mosi_seen, wire_order(t, l));
        check({tag, "_edges"}, n_edges, 2 * DW);
        check({tag, "_rx_data"}, rx_data, exp_rx);
        check({tag, "_ss_n_low"}, ssn_bad, 0);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_done_once"}, done_n, 1);
    endtask

    initial begin
        logic [DW-1:0] t, mw;
        logic          l, p;
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        tx_data  = '0;
        lsb      = 1'b0;
        pha      = 1'b0;
        loopback = 1'b0;
        miso_word = '0;
        div      = 2;
        div_cnt  = 0;
        edge_idx = 0;
        clear_obs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_ss_n", ss_n, 1);
        check("rst_enables", {en_tick, en_sck, en_lc}, 0);
        check("rst_busy_done_mosi", {busy, done, mosi}, 0);
        check("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // MSB first, CPHA=0, loopback
        start_xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 2);
        wait_done("t1");
        check_xfer("t1", 8'hA5, 1'b0, 8'hA5);

        // Abort mid-transfer keeps the previous word
        start_xfer(8'h5A, 8'h0F, 1'b0, 1'b0, 1'b0, 3);
        wait_edges("t4", 7);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("t4_ss_n", ss_n, 1);
        check("t4_enables", {en_tick, en_sck, en_lc}, 0);
        check("t4_busy", busy, 0);
        check("t4_rx_kept", rx_data, 8'hA5);
        repeat (20) @(negedge clk);
        #1;
        check("t4_no_done", done_n, 0);

        // Abort with start in idle: nothing happens
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("idle_abort_start_busy", {busy, ss_n}, 2'b01);

        // CPHA=1, LSB first
        start_xfer(8'h3C, 8'h96, 1'b1, 1'b1, 1'b0, 2);
        wait_done("t2");
        check_xfer("t2", 8'h3C, 1'b1, 8'h96);

        // A start while busy is ignored
        start_xfer(8'hC3, 8'h6B, 1'b0, 1'b1, 1'b0, 3);
        wait_edges("t3", 5);
        tx_data = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done("t3");
        check_xfer("t3", 8'hC3, 1'b0, 8'h6B);

        // Start held through done: back-to-back with one cycle of ss_n high
        start_xfer(8'h81, 8'h5C, 1'b0, 1'b0, 1'b0, 2);
        start = 1'b1;
        wait_done("t6a");
        check("t6_rx_first", rx_data, 8'h5C);
        check("t6_gap_ss_n_high", ss_n, 1);
        clear_obs();
        @(negedge clk);
        #1;
        check("t6_restart", {ss_n, busy}, 2'b01);
        start = 1'b0;
        wait_done("t6b");
        check_xfer("t6b", 8'h81, 1'b0, 8'h5C);

        // Randomised transfers
        for (int i = 0; i < 16; i++) begin
            t  = DW'($urandom);
            mw = DW'($urandom);
            l  = 1'($urandom);
            p  = 1'($urandom);
            start_xfer(t, mw, l, p, 1'b0, int'($urandom_range(2, 4)));
            wait_done("rnd");
            check_xfer("rnd", t, l, mw);
        end

        // Asynchronous reset mid-transfer, then recovery
        start_xfer(8'hE7, 8'h42, 1'b1, 1'b0, 1'b0, 2);
        wait_edges("t5", 9);
        #2 rst_n = 1'b0;
        #1;
        check("t5_ss_n", ss_n, 1);
        check("t5_enables", {en_tick, en_sck, en_lc}, 0);
        check("t5_busy_done_mosi", {busy, done, mosi}, 0);
        check("t5_rx_data", rx_data, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        start_xfer(8'h1D, 8'hB8, 1'b1, 1'b1, 1'b0, 4);
        wait_done("post_rst");
        check_xfer("post_rst", 8'h1D, 1'b1, 8'hB8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
